// File: rtl/booth_pipe_mult.sv
// Pipelined radix-2 Booth multiplier with valid/ready flow control, signed/unsigned
// mode and a pass-through tag. STAGES Booth stages followed by a fix-up/output stage.
module booth_pipe_mult #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_STAGE = 16,
    parameter int TAG_W           = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [TAG_W-1:0]     tag_o
);

    localparam int STAGES = WIDTH / STEPS_PER_STAGE;
    localparam int SW     = 2 * WIDTH + 2;

    // st layout: {acc[WIDTH:0], Q[WIDTH-1:0], q0}
    typedef struct packed {
        logic [SW-1:0]    st;
        logic [WIDTH-1:0] maga;
        logic             msb;
        logic             neg;
        logic [TAG_W-1:0] tag;
        logic             valid;
    } stage_t;

    function automatic logic [SW-1:0] booth_steps(input logic [SW-1:0] st_in,
                                                  input logic [WIDTH-1:0] maga);
        logic [SW-1:0]  v;
        logic [WIDTH:0] acc;
        v = st_in;
        for (int k = 0; k < STEPS_PER_STAGE; k++) begin
            acc = v[SW-1:WIDTH+1];
            case (v[1:0])
                2'b01:   acc = acc + {1'b0, maga};
                2'b10:   acc = acc - {1'b0, maga};
                default: acc = acc;
            endcase
            v = {acc, v[WIDTH:0]};
            v = {v[SW-1], v[SW-1:1]};
        end
        return v;
    endfunction

    logic             advance_s;
    logic [WIDTH-1:0] maga_s;
    logic [WIDTH-1:0] magb_s;
    stage_t           entry_s;
    stage_t           load_s [STAGES];
    stage_t           pipe_r [STAGES];
    stage_t           last_s;
    logic [2*WIDTH-1:0] raw_s;
    logic [2*WIDTH-1:0] fix_s;
    logic [2*WIDTH-1:0] res_s;
    logic             unused_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Operand magnitudes and result sign; the Booth core only ever sees magnitudes.
    always_comb begin
        if (signed_mode_i && multiplicand_i[WIDTH-1]) begin
            maga_s = -multiplicand_i;
        end else begin
            maga_s = multiplicand_i;
        end
        if (signed_mode_i && multiplier_i[WIDTH-1]) begin
            magb_s = -multiplier_i;
        end else begin
            magb_s = multiplier_i;
        end
        entry_s.st    = {{(WIDTH+1){1'b0}}, magb_s, 1'b0};
        entry_s.maga  = maga_s;
        entry_s.msb   = magb_s[WIDTH-1];
        entry_s.neg   = signed_mode_i & (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
        entry_s.tag   = tag_i;
        entry_s.valid = in_valid & advance_s;
    end

    // Next contents of every stage: previous stage plus this stage's Booth substeps.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                load_s[s] = entry_s;
            end else begin
                load_s[s] = pipe_r[s-1];
            end
            load_s[s].st = booth_steps(load_s[s].st, load_s[s].maga);
        end
    end

    // Booth stage registers; the whole pipe, bubbles included, moves only on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe_r[s] <= '0;
            end
        end else if (advance_s) begin
            for (int s = 0; s < STAGES; s++) begin
                pipe_r[s] <= load_s[s];
            end
        end
    end

    assign last_s   = pipe_r[STAGES-1];
    assign unused_s = ^{last_s.st[SW-1], last_s.st[0]};

    // Booth read magB's MSB as a sign bit: add magA<<WIDTH back, then apply the sign.
    always_comb begin
        raw_s = last_s.st[2*WIDTH:1];
        if (last_s.msb) begin
            fix_s = raw_s + {last_s.maga, {WIDTH{1'b0}}};
        end else begin
            fix_s = raw_s;
        end
        if (last_s.neg) begin
            res_s = -fix_s;
        end else begin
            res_s = fix_s;
        end
    end

    // Output register; data only changes when a real result is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            product_o <= '0;
            tag_o     <= '0;
        end else if (advance_s) begin
            out_valid <= last_s.valid;
            if (last_s.valid) begin
                product_o <= res_s;
                tag_o     <= last_s.tag;
            end
        end
    end

endmodule

// File: tb/tb_booth_pipe_mult.sv
// Self-checking bench: a 32-bit default instance and an 8-bit, 1-step-per-stage instance,
// both scored against an arithmetic reference with in-order scoreboards.
module tb_booth_pipe_mult;

    localparam int W     = 32;
    localparam int W8    = 8;
    localparam int TW    = 4;
    localparam int A_LAT = 3;
    localparam int B_LAT = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          a_in_valid, a_in_ready, a_signed, a_out_valid, a_out_ready;
    logic [W-1:0]  a_a, a_b;
    logic [TW-1:0] a_tag, a_tag_o;
    logic [2*W-1:0] a_prod;

    logic          b_in_valid, b_in_ready, b_signed, b_out_valid, b_out_ready;
    logic [W8-1:0] b_a, b_b;
    logic [TW-1:0] b_tag, b_tag_o;
    logic [2*W8-1:0] b_prod;

    booth_pipe_mult dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .signed_mode_i(a_signed), .multiplicand_i(a_a), .multiplier_i(a_b), .tag_i(a_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .product_o(a_prod), .tag_o(a_tag_o)
    );

    booth_pipe_mult #(.WIDTH(W8), .STEPS_PER_STAGE(1), .TAG_W(TW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .signed_mode_i(b_signed), .multiplicand_i(b_a), .multiplier_i(b_b), .tag_i(b_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .product_o(b_prod), .tag_o(b_tag_o)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [2*W+TW-1:0]  a_q [$];
    logic [2*W8+TW-1:0] b_q [$];
    logic               a_hold, b_hold, a_acc, b_acc, a_pend, b_pend;
    logic [2*W+TW-1:0]  a_held;
    logic [2*W8+TW-1:0] b_held;

    function automatic logic [2*W-1:0] ref32(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'({32'd0, x}) * longint'({32'd0, y});
        return p[63:0];
    endfunction

    function automatic logic [2*W8-1:0] ref8(input logic s, input logic [W8-1:0] x, input logic [W8-1:0] y);
        int p;
        if (s) p = int'($signed(x)) * int'($signed(y));
        else   p = int'({24'd0, x}) * int'({24'd0, y});
        return p[15:0];
    endfunction

    function automatic logic [W-1:0] rand32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: scoreboard both DUTs at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        a_acc = 1'b0;
        b_acc = 1'b0;
        if (!rst_n) begin
            a_q.delete();
            b_q.delete();
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (a_hold) begin
                chk("a_hold_valid", a_out_valid, 1'b1);
                chk("a_hold_data", {a_prod, a_tag_o}, a_held);
            end
            chk("a_in_ready", a_in_ready, !a_out_valid || a_out_ready);
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) chk("a_extra_result", a_out_valid, 1'b0);
                else                 chk("a_result", {a_prod, a_tag_o}, a_q.pop_front());
            end
            a_hold = a_out_valid && !a_out_ready;
            a_held = {a_prod, a_tag_o};
            if (a_in_valid && a_in_ready) begin
                a_q.push_back({ref32(a_signed, a_a, a_b), a_tag});
                a_acc = 1'b1;
            end
            if (b_hold) begin
                chk("b_hold_valid", b_out_valid, 1'b1);
                chk("b_hold_data", {b_prod, b_tag_o}, b_held);
            end
            chk("b_in_ready", b_in_ready, !b_out_valid || b_out_ready);
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) chk("b_extra_result", b_out_valid, 1'b0);
                else                 chk("b_result", {b_prod, b_tag_o}, b_q.pop_front());
            end
            b_hold = b_out_valid && !b_out_ready;
            b_held = {b_prod, b_tag_o};
            if (b_in_valid && b_in_ready) begin
                b_q.push_back({ref8(b_signed, b_a, b_b), b_tag});
                b_acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k < 40 && (a_q.size() > 0 || b_q.size() > 0 || a_out_valid || b_out_valid); k++) tick();
        chk("drain_a_pending", a_q.size(), 0);
        chk("drain_b_pending", b_q.size(), 0);
    endtask

    task automatic single_a(input string name, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [TW-1:0] t, input logic [2*W-1:0] exp);
        a_in_valid = 1'b1; a_signed = s; a_a = x; a_b = y; a_tag = t; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 1; k < A_LAT; k++) begin
            chk({name, "_early"}, a_out_valid, 1'b0);
            tick();
        end
        chk({name, "_valid"}, a_out_valid, 1'b1);
        chk({name, "_prod"}, a_prod, exp);
        chk({name, "_tag"}, a_tag_o, t);
        tick();
    endtask

    task automatic single_b(input string name, input logic s, input logic [W8-1:0] x, input logic [W8-1:0] y,
                            input logic [TW-1:0] t, input logic [2*W8-1:0] exp);
        b_in_valid = 1'b1; b_signed = s; b_a = x; b_b = y; b_tag = t; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        for (int k = 1; k < B_LAT; k++) begin
            chk({name, "_early"}, b_out_valid, 1'b0);
            tick();
        end
        chk({name, "_valid"}, b_out_valid, 1'b1);
        chk({name, "_prod"}, b_prod, exp);
        chk({name, "_tag"}, b_tag_o, t);
        tick();
    endtask

    initial begin
        logic [3:0] pat;
        int         issued;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_signed = 1'b1; a_a = '0; a_b = '0; a_tag = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_signed = 1'b1; b_a = '0; b_b = '0; b_tag = '0; b_out_ready = 1'b1;
        a_hold = 1'b0; b_hold = 1'b0; a_pend = 1'b0; b_pend = 1'b0;
        a_held = '0; b_held = '0; a_acc = 1'b0; b_acc = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_product", a_prod, 64'h0);
        chk("rst_tag", a_tag_o, 4'h0);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", a_in_ready, 1'b1);

        single_a("neg7x6", 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 4'h3, 64'hFFFF_FFFF_FFFF_FFD6);
        single_a("min_x_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h5, 64'h4000_0000_0000_0000);
        single_a("min_x_1", 1'b1, 32'h8000_0000, 32'h0000_0001, 4'h6, 64'hFFFF_FFFF_8000_0000);
        single_a("zero_x_neg5", 1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 4'h7, 64'h0);
        single_a("umax_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h9, 64'hFFFF_FFFE_0000_0001);
        single_a("neg1_sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 64'h1);
        single_b("b_min_sq", 1'b1, 8'h80, 8'h80, 4'h1, 16'h4000);
        single_b("b_umax_sq", 1'b0, 8'hFF, 8'hFF, 4'h2, 16'hFE01);

        // Back-to-back issue with out_ready cycling 1,0,0,1.
        pat = 4'b1001;
        issued = 0;
        a_in_valid = 1'b1; a_signed = 1'($urandom); a_a = rand32(); a_b = rand32(); a_tag = 4'($urandom);
        for (int c = 0; c < 200 && issued < 8; c++) begin
            a_out_ready = pat[c % 4];
            tick();
            if (a_acc) begin
                issued = issued + 1;
                a_signed = 1'($urandom); a_a = rand32(); a_b = rand32(); a_tag = 4'($urandom);
            end
        end
        a_in_valid = 1'b0;
        chk("b2b_issued", issued, 8);
        drain();

        // Reset while three operations are in flight.
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_signed = 1'b1; a_a = rand32(); a_b = rand32(); a_tag = 4'(k + 1);
            tick();
        end
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", a_out_valid, 1'b0);
        chk("midrst_product", a_prod, 64'h0);
        for (int k = 0; k < A_LAT + 3; k++) begin
            tick();
            chk("midrst_no_stale", a_out_valid, 1'b0);
        end

        // Random traffic on both instances with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            if (!a_pend) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_signed = 1'($urandom); a_a = rand32(); a_b = rand32(); a_tag = 4'($urandom);
            end
            if (!b_pend) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_signed = 1'($urandom); b_a = 8'($urandom); b_b = 8'($urandom); b_tag = 4'($urandom);
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            tick();
            a_pend = a_in_valid && !a_acc;
            b_pend = b_in_valid && !b_acc;
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
